sprite_row_renderer: RTL

Downstream consumer of the 8×16 glyph ROM (`sprite`) in the Pitfall video path. For one sprite per frame, it compares the VGA controller's current pixel position against a frame-latched sprite position and code. It drives the ROM row address and serializes the returned 8-bit row into a per-pixel `pixel_on` flag for the colour mapper. Sprite position and code are latched once per frame, so game logic may update them at any time without tearing.

---
 rtl/sprite_pkg.sv | 15 +
 rtl/sprite_row_shifter.sv | 71 +++++++
 rtl/sprite_row_renderer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and sizes for the sprite row renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } sprite_state_t;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 16;
    localparam int CODE_W   = 4;

endpackage

// File: rtl/sprite_row_shifter.sv
// Serializes one glyph row into pixel_on; optional bit reversal on load (SPRITE_MIRROR_EN).
// Latency: pixel_on updates on the clock edge of the load/shift/clear strobe.
// Backpressure: none; with no strobe asserted every register holds.
module sprite_row_shifter
    import sprite_pkg::*;
#(
    parameter int W = SPRITE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         clear,
    input  logic [W-1:0] load_dat,
`ifdef SPRITE_MIRROR_EN
    input  logic         mirror,
`endif
    output logic         pixel_on,
    output logic         cnt_zero
);

    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pixel_on_q, pixel_on_d;
    logic [W-1:0]     load_bits;

    // Load a fresh row (MSB = leftmost pixel), walk it left one pixel per shift, or blank the output.
    always_comb begin
        load_bits = load_dat;
`ifdef SPRITE_MIRROR_EN
        if (mirror) begin
            for (int i = 0; i < W; i++) begin
                load_bits[i] = load_dat[W-1-i];
            end
        end
`endif
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        pixel_on_d = pixel_on_q;
        if (load) begin
            shift_d    = load_bits;
            cnt_d      = CNT_W'(W - 1);
            pixel_on_d = load_bits[W-1];
        end else if (shift) begin
            shift_d    = shift_q << 1;
            cnt_d      = cnt_q - CNT_W'(1);
            pixel_on_d = shift_q[W-2];
        end else if (clear) begin
            pixel_on_d = 1'b0;
        end
    end

    // Shift register, remaining-pixel counter and registered pixel output.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            pixel_on_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pixel_on_q <= pixel_on_d;
        end
    end

    assign pixel_on = pixel_on_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/sprite_row_renderer.sv
// Single-sprite row renderer: frame-latched position/code, glyph ROM addressing, per-pixel pixel_on (SPRITE_MIRROR_EN adds mirror).
// Latency: rom_addr combinational; pixel_on/busy valid one clock after the pix_en sample they describe.
// Backpressure: none; one pixel per pix_en, all pixel state holds while pix_en is low.
module sprite_row_renderer #(
    parameter int COORD_W  = 10,
    parameter int SPRITE_W = sprite_pkg::SPRITE_W,
    parameter int SPRITE_H = sprite_pkg::SPRITE_H
) (
    input  logic                                           Clk,
    input  logic                                           Reset,
    input  logic                                           pix_en,
    input  logic                                           frame_start,
    input  logic [COORD_W-1:0]                             DrawX,
    input  logic [COORD_W-1:0]                             DrawY,
    input  logic [COORD_W-1:0]                             sprite_x,
    input  logic [COORD_W-1:0]                             sprite_y,
    input  logic [sprite_pkg::CODE_W-1:0]                  sprite_code,
`ifdef SPRITE_MIRROR_EN
    input  logic                                           mirror,
`endif
    output logic [sprite_pkg::CODE_W+$clog2(SPRITE_H)-1:0] rom_addr,
    input  logic [SPRITE_W-1:0]                            rom_data,
    output logic                                           pixel_on,
    output logic                                           busy
);

    import sprite_pkg::*;

    localparam int ROW_W = $clog2(SPRITE_H);

    sprite_state_t     state_q, state_d;
    logic              busy_q, busy_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [COORD_W-1:0] row;
    logic              hit;
    logic              load, shift, clear;
    logic              cnt_zero;

    // Shadow copies of the game-logic request, refreshed only at frame start so a frame never tears.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        code_d = code_q;
        if (frame_start) begin
            x_d    = sprite_x;
            y_d    = sprite_y;
            code_d = sprite_code;
        end
    end

    // Glyph row for the current scanline; the modular subtract gives top clipping for y near the wrap.
    always_comb begin
        row      = DrawY - y_q;
        hit      = (row < COORD_W'(SPRITE_H));
        rom_addr = {code_q, row[ROW_W-1:0]};
    end

    // Row FSM: wait for the left edge, then run exactly SPRITE_W samples unless the line wraps first.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        clear   = 1'b0;
        if (pix_en) begin
            case (state_q)
                IDLE: begin
                    if (hit && (DrawX == x_q)) begin
                        load    = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        clear = 1'b1;
                    end
                end
                ACTIVE: begin
                    if ((DrawX == '0) || cnt_zero) begin
                        clear   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
                default: begin
                    clear   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d == ACTIVE);
    end

    // State, busy flag and shadow registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            x_q     <= x_d;
            y_q     <= y_d;
            code_q  <= code_d;
        end
    end

`ifdef SPRITE_MIRROR_EN
    logic mirror_q, mirror_d;

    // Facing direction is latched with the rest of the frame state.
    always_comb begin
        mirror_d = frame_start ? mirror : mirror_q;
    end

    // Mirror shadow register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mirror_q <= 1'b0;
        end else begin
            mirror_q <= mirror_d;
        end
    end
`endif

    sprite_row_shifter #(
        .W (SPRITE_W)
    ) u_shifter (
        .clk      (Clk),
        .reset    (Reset),
        .load     (load),
        .shift    (shift),
        .clear    (clear),
        .load_dat (rom_data),
`ifdef SPRITE_MIRROR_EN
        .mirror   (mirror_q),
`endif
        .pixel_on (pixel_on),
        .cnt_zero (cnt_zero)
    );

    assign busy = busy_q;

endmodule
